// File: rtl/ram_port_arbiter.sv
// Two-requester front end for a single-port, negedge-clocked data RAM.
// Round-robin between requester 0 and requester 1. A write is a single beat;
// a read is an incrementing burst of len+1 beats. The RAM address, write
// enable and write data all come straight from registers. Read data comes
// back from the RAM one cycle after the beat is issued.
module ram_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int LEN_WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]    p0_wdata,
  input  logic [LEN_WIDTH-1:0]     p0_len,
  output logic                     p0_gnt,
  output logic                     p0_rvalid,
  output logic [DATA_WIDTH-1:0]    p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p1_wdata,
  input  logic [LEN_WIDTH-1:0]     p1_len,
  output logic                     p1_gnt,
  output logic                     p1_rvalid,
  output logic [DATA_WIDTH-1:0]    p1_rdata,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     last_q, last_d;
  logic [LEN_WIDTH-1:0]     beats_left_q, beats_left_d;
  logic                     ram_wEn_q, ram_wEn_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]    ram_dataIn_q, ram_dataIn_d;
  logic [1:0]               rvalid_q, rvalid_d;

  // Requester inputs gathered into arrays so the selected one is picked by index.
  logic [1:0]               req_v, we_v, gnt_v;
  logic [ADDRESS_WIDTH-1:0] addr_v  [2];
  logic [DATA_WIDTH-1:0]    wdata_v [2];
  logic [LEN_WIDTH-1:0]     len_v   [2];
  logic                     sel;

  assign req_v      = {p1_req, p0_req};
  assign we_v       = {p1_we, p0_we};
  assign addr_v[0]  = p0_addr;
  assign addr_v[1]  = p1_addr;
  assign wdata_v[0] = p0_wdata;
  assign wdata_v[1] = p1_wdata;
  assign len_v[0]   = p0_len;
  assign len_v[1]   = p1_len;
  assign sel        = gnt_v[1];

  // Grants exist only in IDLE and outside reset. A tie goes to the requester
  // that was not granted last, so last_q == 1 favours requester 0.
  always_comb begin
    gnt_v = 2'b00;
    if (reset_n && state_q == IDLE) begin
      gnt_v[0] = req_v[0] && (!req_v[1] || last_q);
      gnt_v[1] = req_v[1] && (!req_v[0] || !last_q);
    end
  end

  // Next-state logic. An accept issues the first beat. In BURST, each further
  // beat walks the address upward until beats_left runs out.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    beats_left_d = beats_left_q;
    ram_wEn_d    = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_dataIn_d = ram_dataIn_q;
    rvalid_d     = 2'b00;
    case (state_q)
      IDLE: begin
        if (|gnt_v) begin
          ram_addr_d    = addr_v[sel];
          ram_wEn_d     = we_v[sel];
          ram_dataIn_d  = wdata_v[sel];
          last_d        = sel;
          owner_d       = sel;
          rvalid_d[sel] = !we_v[sel];
          if (!we_v[sel] && len_v[sel] != '0) begin
            beats_left_d = len_v[sel];
            state_d      = BURST;
          end
        end
      end
      BURST: begin
        ram_addr_d        = ram_addr_q + ADDRESS_WIDTH'(1);
        rvalid_d[owner_q] = 1'b1;
        beats_left_d      = beats_left_q - LEN_WIDTH'(1);
        // The final beat goes out on the same edge as the return to IDLE,
        // so there is no dead cycle before the next grant.
        if (beats_left_q == LEN_WIDTH'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and RAM-side registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      beats_left_q <= '0;
      ram_wEn_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_dataIn_q <= '0;
      rvalid_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      beats_left_q <= beats_left_d;
      ram_wEn_q    <= ram_wEn_d;
      ram_addr_q   <= ram_addr_d;
      ram_dataIn_q <= ram_dataIn_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign p0_gnt     = gnt_v[0];
  assign p1_gnt     = gnt_v[1];
  assign p0_rvalid  = rvalid_q[0];
  assign p1_rvalid  = rvalid_q[1];
  assign p0_rdata   = ram_dataOut;
  assign p1_rdata   = ram_dataOut;
  assign ram_wEn    = ram_wEn_q;
  assign ram_addr   = ram_addr_q;
  assign ram_dataIn = ram_dataIn_q;

endmodule
